// File: rtl/uart_frame_sched.sv
// Shares one UART byte transmitter between two 32-bit word producers: round-robin
// grant, 6-byte framing (header, data MSB-first, XOR checksum) and a per-byte ack watchdog.
module uart_frame_sched #(
    parameter logic [7:0] HEADER_BASE = 8'hA0,
    parameter int         TIMEOUT     = 2000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_word0,
    input  logic [31:0] in_word1,
    output logic [1:0]  in_ready,
    output logic [7:0]  uart_data,
    output logic        send_uart_data,
    input  logic        uart_data_sent,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_ABORT  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_SAT    = WD_W'(TIMEOUT);
    localparam logic [2:0]      LAST_BYTE = 3'd5;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;

    logic [1:0]      state;
    logic [31:0]     word_q;
    logic            id_q;
    logic            last_grant;
    logic [2:0]      byte_idx;
    logic [WD_W-1:0] wd;

    logic            grant_id;
    logic            accept;
    logic [31:0]     grant_word;
    logic [2:0]      next_idx;

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] w,
                                              input logic        id);
        case (idx)
            3'd0:    frame_byte = HEADER_BASE | {7'b0, id};
            3'd1:    frame_byte = w[31:24];
            3'd2:    frame_byte = w[23:16];
            3'd3:    frame_byte = w[15:8];
            3'd4:    frame_byte = w[7:0];
            default: frame_byte = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        grant_id = 1'b0;
        case (in_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        in_ready = 2'b00;
        if (state == IDLE && in_valid != 2'b00) begin
            in_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign accept     = |(in_valid & in_ready);
    assign grant_word = grant_id ? in_word1 : in_word0;
    assign busy       = (state != IDLE);
    assign next_idx   = byte_idx + 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            word_q         <= '0;
            id_q           <= 1'b0;
            last_grant     <= 1'b1;
            byte_idx       <= '0;
            wd             <= '0;
            uart_data      <= 8'h00;
            send_uart_data <= 1'b0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            send_uart_data <= 1'b0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q         <= grant_word;
                        id_q           <= grant_id;
                        last_grant     <= grant_id;
                        byte_idx       <= '0;
                        uart_data      <= frame_byte(3'd0, grant_word, grant_id);
                        send_uart_data <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    // wd counts cycles elapsed since the send pulse; the pulse cycle is the first.
                    wd    <= {{(WD_W-1){1'b0}}, 1'b1};
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (uart_data_sent) begin
                        if (byte_idx == LAST_BYTE) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            byte_idx       <= next_idx;
                            uart_data      <= frame_byte(next_idx, word_q, id_q);
                            send_uart_data <= 1'b1;
                            state          <= SEND;
                        end
                    end else begin
                        if (wd != WD_SAT) begin
                            wd <= wd + 1'b1;
                        end
                        if (wd == WD_ABORT) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched: randomized words and ack delays against a
// frame/arbitration reference model, plus directed tie, back-pressure, timeout and reset cases.
module tb_uart_frame_sched;

    localparam int         TIMEOUT = 50;
    localparam logic [7:0] HB      = 8'hA0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  in_valid;
    logic [31:0] in_word0;
    logic [31:0] in_word1;
    logic [1:0]  in_ready;
    logic [7:0]  uart_data;
    logic        send_uart_data;
    logic        uart_data_sent;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    logic tx_ack   = 1'b0;
    logic spur_ack = 1'b0;
    assign uart_data_sent = tx_ack | spur_ack;

    bit         tx_enable    = 1'b1;
    int         tx_delay_max = 6;
    int         ack_cnt      = 0;
    int         neg_cnt      = 0;
    int         last_ack_neg = -1;
    int         gap_bad      = 0;
    logic [7:0] sent_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int model_last = 1;

    uart_frame_sched #(.HEADER_BASE(HB), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_word0       (in_word0),
        .in_word1       (in_word1),
        .in_ready       (in_ready),
        .uart_data      (uart_data),
        .send_uart_data (send_uart_data),
        .uart_data_sent (uart_data_sent),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    // Transmitter model: captures each requested byte, acks after a random delay.
    always @(negedge clock) begin
        neg_cnt++;
        tx_ack = 1'b0;
        if (!reset_n) begin
            ack_cnt      = 0;
            last_ack_neg = -1;
        end else begin
            if (!busy) last_ack_neg = -1;
            if (send_uart_data) begin
                sent_q.push_back(uart_data);
                if (last_ack_neg >= 0 && neg_cnt - last_ack_neg != 1) gap_bad++;
                ack_cnt = int'($urandom_range(tx_delay_max, 1));
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0 && tx_enable) begin
                    tx_ack       = 1'b1;
                    last_ack_neg = neg_cnt;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int id, input logic [31:0] w, input int k);
        logic [7:0] d[4];
        d[0] = w[31:24]; d[1] = w[23:16]; d[2] = w[15:8]; d[3] = w[7:0];
        if (k == 0) return HB + 8'(id);
        if (k <= 4) return d[k-1];
        return d[0] ^ d[1] ^ d[2] ^ d[3];
    endfunction

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - model_last;
        return v[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers v in IDLE, checks the grant and the header send pulse; optionally keeps the loser valid.
    task automatic send_word(input logic [1:0] v, input logic [31:0] w0, input logic [31:0] w1,
                             input bit keep, output int id, output logic [1:0] left);
        in_valid = v; in_word0 = w0; in_word1 = w1;
        #1;
        id = pick(v);
        check("grant", in_ready, 64'(2'b01 << id));
        sent_q.delete();
        tick();
        model_last = id;
        left = keep ? (v & ~(2'b01 << id)) : 2'b00;
        in_valid = left;
        check("send_pulse", send_uart_data, 1);
        check("header_byte", uart_data, exp_byte(id, id ? w1 : w0, 0));
        check("busy_in_send", busy, 1);
        check("ready_low_in_send", in_ready, 0);
        check("frame_done_width", frame_done, 0);
    endtask

    task automatic finish_frame(input int id, input logic [31:0] w, input logic [1:0] ready_at_done);
        int  n = 0;
        int  bad_ready = 0;
        bit  done = 1'b0;
        bit  tmo = 1'b0;
        while (!done && !tmo && n < 2000) begin
            tick();
            n++;
            if (frame_done) done = 1'b1;
            else if (timeout_err) tmo = 1'b1;
            else if (in_ready != 2'b00) bad_ready++;
        end
        check("frame_done_seen", done, 1);
        check("ready_while_busy", bad_ready, 0);
        check("busy_at_done", busy, 0);
        check("ready_at_done", in_ready, ready_at_done);
        check("inter_byte_gap", gap_bad, 0);
        check("byte_count", sent_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < sent_q.size()) check($sformatf("byte%0d", k), sent_q[k], exp_byte(id, w, k));
        end
    endtask

    initial begin
        int          id;
        int          n;
        bit          found;
        bit          saw_done;
        logic [1:0]  left;
        logic [1:0]  hold;
        logic [31:0] w0;
        logic [31:0] w1;

        reset_n = 1'b0; in_valid = 2'b00; in_word0 = '0; in_word1 = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_send", send_uart_data, 0);
        check("rst_data", uart_data, 8'h00);
        check("rst_ready", in_ready, 0);
        check("rst_done", frame_done, 0);
        check("rst_tmo", timeout_err, 0);
        reset_n = 1'b1;
        tick();

        // Tie from reset: requester 0 first, requester 1 held and back-pressured.
        send_word(2'b11, 32'hDEADBEEF, 32'h00000001, 1'b1, id, left);
        check("tie_first_id", id, 0);
        finish_frame(id, 32'hDEADBEEF, 2'b10);
        send_word(2'b10, 32'hDEADBEEF, 32'h00000001, 1'b0, id, left);
        finish_frame(id, 32'h00000001, 2'b00);
        send_word(2'b11, 32'h0BADF00D, 32'h55AA55AA, 1'b0, id, left);
        check("tie_alternate_id", id, 0);
        finish_frame(id, 32'h0BADF00D, 2'b00);

        send_word(2'b01, 32'h12345678, 32'h0, 1'b0, id, left);
        finish_frame(id, 32'h12345678, 2'b00);

        // Spurious acks in IDLE and in SEND must not advance anything.
        spur_ack = 1'b1; tick(); spur_ack = 1'b0;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_send", send_uart_data, 0);
        send_word(2'b01, 32'hCAFE0042, 32'h0, 1'b0, id, left);
        spur_ack = 1'b1; tick(); spur_ack = 1'b0;
        check("spur_send_nopulse", send_uart_data, 0);
        check("spur_send_busy", busy, 1);
        check("spur_send_held", uart_data, exp_byte(id, 32'hCAFE0042, 0));
        finish_frame(id, 32'hCAFE0042, 2'b00);

        // Watchdog: transmitter goes silent.
        tx_enable = 1'b0;
        send_word(2'b10, 32'h0, 32'h89ABCDEF, 1'b0, id, left);
        n = 0; saw_done = 1'b0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
            if (frame_done) saw_done = 1'b1;
        end
        check("timeout_latency", n, TIMEOUT);
        check("timeout_busy", busy, 0);
        check("timeout_no_done", saw_done, 0);
        check("timeout_bytes", sent_q.size(), 1);
        tick();
        check("timeout_width", timeout_err, 0);
        tx_enable = 1'b1;
        send_word(2'b11, 32'h13579BDF, 32'h2468ACE0, 1'b0, id, left);
        check("after_timeout_id", id, 0);
        finish_frame(id, 32'h13579BDF, 2'b00);

        // Reset while byte 3 is being requested.
        tx_delay_max = 4;
        send_word(2'b01, 32'hA1B2C3D4, 32'h0, 1'b0, id, left);
        found = 1'b0; n = 0;
        while (!found && n < 500) begin
            tick();
            n++;
            if (send_uart_data && sent_q.size() == 3) found = 1'b1;
        end
        check("reached_byte3", found, 1);
        check("byte3_pending", uart_data, exp_byte(id, 32'hA1B2C3D4, 3));
        reset_n = 1'b0;
        #1;
        check("midrst_send", send_uart_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", uart_data, 8'h00);
        tick(); tick();
        reset_n = 1'b1;
        model_last = 1;
        tick();
        send_word(2'b11, 32'h600DCAFE, 32'h7777_0000, 1'b0, id, left);
        check("post_rst_tie_id", id, 0);
        finish_frame(id, 32'h600DCAFE, 2'b00);

        // Randomized traffic with optional held losers and random ack delays.
        hold = 2'b00; w0 = 32'h0; w1 = 32'h0;
        for (int i = 0; i < 20; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(3, 1)) | hold;
            if (!hold[0]) w0 = $urandom();
            if (!hold[1]) w1 = $urandom();
            tx_delay_max = int'($urandom_range(12, 1));
            send_word(v, w0, w1, 1'($urandom_range(1, 0)), id, left);
            finish_frame(id, id ? w1 : w0, left);
            hold = left;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
